// File: rtl/et_pkg.sv
`default_nettype none
// ============================================================================
// et_pkg : shared FSM state type and bit-reversal helper for et_sng.
// Rev 1.0
// ============================================================================
package et_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned MAX_W = 32;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v,
                                                input int unsigned      w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = v[MAX_W-1-i];
        end
        return r >> (MAX_W - w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/et_sng_masked_ctr.sv
`default_nettype none
// ============================================================================
// masked_ctr : one counter group (mask register, masked counter, wrap flag).
// Rev 1.0
// ============================================================================
module masked_ctr
    import et_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         adv_i,
    input  logic [W-1:0] s_i,
    output logic [W-1:0] r_o,
    output logic         wrap_o,
    output logic         wr_o
);

    logic [W-1:0] m_q, m_d;
    logic [W-1:0] c_q, c_d;
    logic         wr_q, wr_d;
    logic [W-1:0] w_or;

    // Forcing masked bits to one lets the carry ripple straight past them.
    assign w_or   = c_q | m_q;
    assign wrap_o = &w_or;

    always_comb begin
        m_d  = m_q;
        c_d  = c_q;
        wr_d = wr_q;
        if (load_i) begin
            m_d  = W'(bitrev(MAX_W'(s_i), W));
            c_d  = '0;
            wr_d = 1'b0;
        end else if (adv_i) begin
            c_d = (w_or + W'(1)) & ~m_q;
            if (wrap_o) begin
                wr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q  <= '0;
            c_q  <= '0;
            wr_q <= 1'b0;
        end else begin
            m_q  <= m_d;
            c_q  <= c_d;
            wr_q <= wr_d;
        end
    end

    assign r_o  = W'(bitrev(MAX_W'(c_q), W));
    assign wr_o = wr_q;

endmodule
`default_nettype wire

// File: rtl/et_sng.sv
`default_nettype none
// ============================================================================
// et_sng : early-termination stochastic number generator.
// Optional: ET_SNG_LEN_OUT_EN adds the len_out bit-count output. Rev 1.0
// ============================================================================
module et_sng
    import et_pkg::*;
#(
    parameter int W        = 8,
    parameter int N        = 2,
    parameter int S_GROUPS = 2,
    parameter int CORR     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*W-1:0]        Bxs,
    input  logic [S_GROUPS*W-1:0] S,
    input  logic [W-1:0]          k_init,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_bits,
    output logic                  out_last,
    output logic [W-1:0]          k_out
`ifdef ET_SNG_LEN_OUT_EN
    ,
    output logic [W:0]            len_out
`endif
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]          state_q, state_d;
    logic [N*W-1:0]      bx_q, bx_d;
    logic [W-1:0]        k_q, k_d;

    logic                w_load;
    logic                w_adv;
    logic [W-1:0]        w_r [S_GROUPS];
    logic [S_GROUPS-1:0] w_wrap;
    logic [S_GROUPS-1:0] w_wr;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RUN);
    assign w_load    = in_valid && in_ready;
    assign w_adv     = out_valid && out_ready;

    // Last bit once every group has either wrapped already or wraps now.
    assign out_last  = out_valid && (&(w_wr | w_wrap));
    assign k_out     = k_q;

    generate
        for (genvar g = 0; g < S_GROUPS; g++) begin : g_grp
            masked_ctr #(
                .W (W)
            ) u_ctr (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (w_load),
                .adv_i  (w_adv),
                .s_i    (S[g*W +: W]),
                .r_o    (w_r[g]),
                .wrap_o (w_wrap[g]),
                .wr_o   (w_wr[g])
            );
        end

        for (genvar j = 0; j < N; j++) begin : g_bit
            localparam int GI = (CORR != 0) ? 0 : j;
            assign out_bits[j] = out_valid && (bx_q[j*W +: W] > w_r[GI]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (w_load) begin
                    state_d = ST_RUN;
                    bx_d    = Bxs;
                    k_d     = k_init;
                end
            end
            ST_RUN: begin
                if (w_adv && out_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bx_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            k_q     <= k_d;
        end
    end

`ifdef ET_SNG_LEN_OUT_EN
    logic [W:0] len_q, len_d;

    always_comb begin
        len_d = len_q;
        if (w_load) begin
            len_d = '0;
        end else if (w_adv) begin
            len_d = len_q + (W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // The bit on display counts as emitted, so the last handshake shows the full length.
    assign len_out = len_q + (W+1)'(out_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_et_sng.sv
`default_nettype none
// ============================================================================
// tb_et_sng : bench for et_sng (W=4): correlated and uncorrelated instances.
// Rev 1.0
// ============================================================================
module tb_et_sng;

    logic            clk;
    logic            rst_n;
    logic [1:0]      in_valid;
    logic [1:0]      out_ready;
    logic [1:0][7:0] bxs;
    logic [1:0][3:0] kin;
    logic [3:0]      s_c;
    logic [7:0]      s_u;

    logic [1:0]      in_rdy;
    logic [1:0]      o_valid;
    logic [1:0][1:0] o_bits;
    logic [1:0]      o_last;
    logic [1:0][3:0] k_o;
`ifdef ET_SNG_LEN_OUT_EN
    logic [1:0][4:0] len_o;
    logic [4:0]      last_len0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    logic [2:0] lg0[$];
    logic [2:0] lg1[$];

    et_sng #(.W(4), .N(2), .S_GROUPS(1), .CORR(1)) dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_rdy[0]),
        .Bxs       (bxs[0]),
        .S         (s_c),
        .k_init    (kin[0]),
        .out_valid (o_valid[0]),
        .out_ready (out_ready[0]),
        .out_bits  (o_bits[0]),
        .out_last  (o_last[0]),
        .k_out     (k_o[0])
`ifdef ET_SNG_LEN_OUT_EN
        ,
        .len_out   (len_o[0])
`endif
    );

    et_sng #(.W(4), .N(2), .S_GROUPS(2), .CORR(0)) dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_rdy[1]),
        .Bxs       (bxs[1]),
        .S         (s_u),
        .k_init    (kin[1]),
        .out_valid (o_valid[1]),
        .out_ready (out_ready[1]),
        .out_bits  (o_bits[1]),
        .out_last  (o_last[1]),
        .k_out     (k_o[1])
`ifdef ET_SNG_LEN_OUT_EN
        ,
        .len_out   (len_o[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       m_run [2];
    int         m_idx [2];
    logic [7:0] m_bx  [2];
    logic [7:0] m_s   [2];
    logic [3:0] m_k   [2];
    logic [1:0] eb;

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic int glen(input int d, input int g);
        return 1 << (4 - $countones(m_s[d][g*4 +: 4]));
    endfunction

    function automatic int slen(input int d);
        int l0, l1;
        l0 = glen(d, 0);
        l1 = (d == 0) ? 0 : glen(d, 1);
        return (l0 > l1) ? l0 : l1;
    endfunction

    // i-th comparison value of group g: the i-th smallest counter value
    // with all masked positions zero, read bit-reversed.
    function automatic logic [3:0] model_r(input int d, input int g, input int i);
        logic [3:0] m;
        logic [3:0] vv;
        int k, n;
        m = rev4(m_s[d][g*4 +: 4]);
        k = i % glen(d, g);
        n = 0;
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            if ((vv & m) == 4'h0) begin
                if (n == k) return rev4(vv);
                n++;
            end
        end
        return 4'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_run[d] <= 1'b0;
                m_idx[d] <= 0;
                m_bx[d]  <= '0;
                m_s[d]   <= '0;
                m_k[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_run[d] && in_valid[d]) begin
                    m_run[d] <= 1'b1;
                    m_idx[d] <= 0;
                    m_bx[d]  <= bxs[d];
                    m_k[d]   <= kin[d];
                    m_s[d]   <= (d == 0) ? {4'h0, s_c} : s_u;
                end else if (m_run[d] && out_ready[d]) begin
                    if (m_idx[d] == slen(d) - 1) m_run[d] <= 1'b0;
                    else                         m_idx[d] <= m_idx[d] + 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && started) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("in_ready%0d", d),  32'(in_rdy[d]),  32'(!m_run[d]));
                chk($sformatf("out_valid%0d", d), 32'(o_valid[d]), 32'(m_run[d]));
                chk($sformatf("k_out%0d", d),     32'(k_o[d]),     32'(m_k[d]));
                if (m_run[d]) begin
                    for (int j = 0; j < 2; j++) begin
                        eb[j] = m_bx[d][j*4 +: 4] > model_r(d, (d == 0) ? 0 : j, m_idx[d]);
                    end
                    chk($sformatf("out_bits%0d", d), 32'(o_bits[d]), 32'(eb));
                    chk($sformatf("out_last%0d", d), 32'(o_last[d]),
                        32'(m_idx[d] == slen(d) - 1));
`ifdef ET_SNG_LEN_OUT_EN
                    chk($sformatf("len_out%0d", d), 32'(len_o[d]), 32'(m_idx[d] + 1));
`endif
                end
                if (o_valid[d] && out_ready[d]) begin
                    if (d == 0) lg0.push_back({o_last[0], o_bits[0]});
                    else        lg1.push_back({o_last[1], o_bits[1]});
`ifdef ET_SNG_LEN_OUT_EN
                    if (d == 0 && o_last[0]) last_len0 = len_o[0];
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int d, input logic [7:0] bx, input logic [3:0] k);
        bxs[d]      = bx;
        kin[d]      = k;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic stream(input int d, input logic [7:0] pat, input int plen);
        int cyc;
        cyc = 0;
        while (o_valid[d] && cyc < 40) begin
            out_ready[d] = (cyc < plen) ? pat[cyc] : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready[d] = 1'b0;
        chk("stream_bound", 32'(cyc < 40), 32'd1);
        chk("stream_seen",  32'(cyc > 0),  32'd1);
        chk("in_ready_after_last", 32'(in_rdy[d]), 32'd1);
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("rst_in_ready%0d", d),  32'(in_rdy[d]),  32'd1);
        chk($sformatf("rst_out_valid%0d", d), 32'(o_valid[d]), 32'd0);
        chk($sformatf("rst_out_bits%0d", d),  32'(o_bits[d]),  32'd0);
        chk($sformatf("rst_out_last%0d", d),  32'(o_last[d]),  32'd0);
        chk($sformatf("rst_k_out%0d", d),     32'(k_o[d]),     32'd0);
`ifdef ET_SNG_LEN_OUT_EN
        chk($sformatf("rst_len_out%0d", d),   32'(len_o[d]),   32'd0);
`endif
    endtask

    // exp holds entry i ({last, bit1, bit0}) at [i*3 +: 3].
    task automatic chk_log(input string nm, input int d, input logic [11:0] exp, input int n);
        int sz;
        logic [2:0] got;
        sz = (d == 0) ? lg0.size() : lg1.size();
        chk({nm, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            got = (d == 0) ? lg0[i] : lg1[i];
            chk($sformatf("%s_bit%0d", nm, i + 1), 32'(got), 32'(exp[i*3 +: 3]));
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        bxs       = '0;
        kin       = '0;
        s_c       = '0;
        s_u       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst_n   = 1'b1;
        started = 1'b1;
        @(posedge clk); #1;

        // Correlated: r = 0,4,2,6; stream0 = 1,0,1,0; stream1 = 1,0,0,0
        s_c = 4'b1001;
        load(0, 8'h24, 4'hA);
        chk("k_out_captured", 32'(k_o[0]), 32'hA);
        stream(0, 8'h00, 0);
        chk_log("corr", 0, 12'b100_001_000_011, 4);
`ifdef ET_SNG_LEN_OUT_EN
        chk("len_out_last", 32'(last_len0), 32'd4);
`endif

        // Uncorrelated: group 1 fully frozen, stream1 constant 1
        s_u = 8'b1111_1001;
        load(1, 8'h24, 4'h5);
        stream(1, 8'h00, 0);
        chk_log("uncorr", 1, 12'b110_011_010_011, 4);

        // Backpressure plus an ignored load request mid-stream
        lg0.delete();
        load(0, 8'h24, 4'h3);
        bxs[0]      = 8'hFF;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        bxs[0]      = 8'h24;
        stream(0, 8'b0000_1001, 4);
        chk_log("stall", 0, 12'b100_001_000_011, 4);

        // All-ones mask: one-bit stream
        lg0.delete();
        s_c = 4'b1111;
        load(0, 8'h01, 4'h8);
        stream(0, 8'h00, 0);
        chk_log("allones", 0, 12'b000_000_000_101, 1);

        // Reset while bit 2 is on display
        s_c = 4'b1001;
        load(0, 8'h24, 4'h6);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        lg0.delete();
        load(0, 8'h24, 4'h6);
        stream(0, 8'h00, 0);
        chk_log("post_reset", 0, 12'b100_001_000_011, 4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
